// File: rtl/sqrt_ctrl.sv
// Sequencing FSM for the 8-bit Babylonian square-root datapath.
// Optional response statistics are built when SQRT_CTRL_STATS_EN is defined.
module sqrt_ctrl #(
    parameter int MIN_ITERS = 2,
    parameter int MAX_ITERS = 12,
    parameter int ITER_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [7:0]        req_data,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic [ITER_W-1:0] rsp_iters,
    output logic              rsp_timeout,
    input  logic              rsp_ready,
    output logic [7:0]        dp_n,
    output logic              dp_ld,
    input  logic [7:0]        dp_result,
    input  logic              dp_flag,
    output logic [15:0]       stat_done,
    output logic [15:0]       stat_tmo
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    localparam logic [ITER_W-1:0] MinCnt = ITER_W'(MIN_ITERS);
    localparam logic [ITER_W-1:0] MaxCnt = ITER_W'(MAX_ITERS);

    state_t            state_q;
    logic [ITER_W-1:0] iter_cnt_q;
    logic [7:0]        dp_n_q;
    logic              dp_ld_q;
    logic              rsp_valid_q;
    logic [7:0]        rsp_data_q;
    logic [ITER_W-1:0] rsp_iters_q;
    logic              rsp_timeout_q;

    logic conv;
    logic at_max;
    logic rsp_hs;

    // Early flags are distrusted: small N can match guess and result spuriously.
    assign conv   = dp_flag && (iter_cnt_q >= MinCnt);
    assign at_max = (iter_cnt_q == MaxCnt);
    assign rsp_hs = rsp_valid_q && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            iter_cnt_q    <= '0;
            dp_n_q        <= '0;
            dp_ld_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_iters_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        dp_n_q <= req_data;
                        if (req_data == 8'd0) begin
                            state_q       <= DONE;
                            rsp_valid_q   <= 1'b1;
                            rsp_data_q    <= '0;
                            rsp_iters_q   <= '0;
                            rsp_timeout_q <= 1'b0;
                        end else begin
                            state_q <= LOAD;
                            dp_ld_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    dp_ld_q    <= 1'b0;
                    iter_cnt_q <= '0;
                    state_q    <= ITER;
                end
                ITER: begin
                    if (conv || at_max) begin
                        state_q       <= DONE;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= dp_result;
                        rsp_iters_q   <= iter_cnt_q;
                        rsp_timeout_q <= !conv;
                    end else begin
                        iter_cnt_q <= iter_cnt_q + ITER_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_iters   = rsp_iters_q;
    assign rsp_timeout = rsp_timeout_q;
    assign dp_n        = dp_n_q;
    assign dp_ld       = dp_ld_q;

`ifdef SQRT_CTRL_STATS_EN
    logic [15:0] stat_done_q, stat_done_d;
    logic [15:0] stat_tmo_q, stat_tmo_d;

    always_comb begin
        stat_done_d = stat_done_q;
        stat_tmo_d  = stat_tmo_q;
        if (rsp_hs) begin
            if (stat_done_q != 16'hFFFF) begin
                stat_done_d = stat_done_q + 16'd1;
            end
            if (rsp_timeout_q && (stat_tmo_q != 16'hFFFF)) begin
                stat_tmo_d = stat_tmo_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_done_q <= '0;
            stat_tmo_q  <= '0;
        end else begin
            stat_done_q <= stat_done_d;
            stat_tmo_q  <= stat_tmo_d;
        end
    end

    assign stat_done = stat_done_q;
    assign stat_tmo  = stat_tmo_q;
`else
    assign stat_done = '0;
    assign stat_tmo  = '0;
`endif

endmodule

// File: doc/sqrt_ctrl.md
Name: sqrt_ctrl

Overview:
Sequencing controller for the 8-bit iterative (Babylonian) square-root datapath. Accepts one operand per valid/ready handshake, loads the datapath, runs the iterations and detects convergence on the datapath flag. Enforces minimum and maximum iteration bounds, then returns the root, the iteration count and a timeout indication over a valid/ready response channel. It sits between a requester (bus slave or CPU-side shim) and one sqrt datapath instance.

Parameters:
MIN_ITERS, 2, iterations before dp_flag is trusted; guards against false early convergence for small N; must be >= 1
MAX_ITERS, 12, iteration limit before timeout; must be >= MIN_ITERS
ITER_W, 4, width of the iteration counter and rsp_iters; must hold MAX_ITERS

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  operand valid
req_data  in  8  operand N
req_ready  out  1  controller can accept an operand
rsp_valid  out  1  result valid
rsp_data  out  8  square-root result
rsp_iters  out  ITER_W  iterations used
rsp_timeout  out  1  MAX_ITERS reached without convergence
rsp_ready  in  1  consumer accepts result
dp_n  out  8  operand to datapath N input (registered)
dp_ld  out  1  datapath load strobe
dp_result  in  8  datapath result
dp_flag  in  1  datapath convergence flag
stat_done  out  16  completed-operation count (see Optional Feature)
stat_tmo  out  16  timeout count (see Optional Feature)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Clock is clk, reset is rst_n.
- While rst_n=0: state=IDLE; dp_n=0, dp_ld=0, rsp_valid=0, rsp_data=0, rsp_iters=0, rsp_timeout=0, iter_cnt=0. Stat counters are 0.
- Reset asserted mid-operation aborts immediately. No response is produced. The datapath is left unloaded until the next request.
- States: IDLE, LOAD, ITER, DONE. All outputs are driven from registers or decoded state only. There are no combinational paths from inputs to outputs.
- IDLE:
  - req_ready=1; it is 1 only in IDLE.
  - On req_valid, capture req_data into dp_n.
  - If req_data==0, go directly to DONE with rsp_data=0, rsp_iters=0, rsp_timeout=0. This avoids a divide-by-zero in the datapath.
  - Otherwise go to LOAD.
- LOAD (exactly 1 cycle):
  - dp_ld=1 and dp_n is held stable; the datapath registers load N, guess=N, result=1 on this edge.
  - iter_cnt is cleared to 0. Next state is ITER.
- ITER:
  - dp_ld=0. Each cycle, evaluate conv = dp_flag && (iter_cnt >= MIN_ITERS).
  - If conv: capture dp_result into rsp_data and iter_cnt into rsp_iters, set rsp_timeout=0, go to DONE.
  - Else if iter_cnt == MAX_ITERS: capture the same registers with rsp_timeout=1, go to DONE.
  - Else iter_cnt++, and the datapath advances one iteration on the same edge.
  - At iter_cnt=k the datapath shows the state after k updates.
- DONE:
  - rsp_valid=1. rsp_data, rsp_iters and rsp_timeout are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid goes to 0 and the state goes to IDLE. A new request is accepted no earlier than the following cycle.
- Latency, nonzero N: 1 (accept) + 1 (LOAD) + (k+1) ITER cycles to rsp_valid, where k is the convergence iteration.
- Convergence and timeout in the same cycle: convergence wins and rsp_timeout=0.
- req_valid in any state other than IDLE is ignored, because req_ready=0.
- Outside LOAD, dp_ld stays low. The datapath may free-run in IDLE/DONE; this is harmless because LOAD always reinitialises it.

Optional Feature:
SQRT_CTRL_STATS_EN
- Defined:
  - stat_done increments on every response handshake.
  - stat_tmo increments on each handshake with rsp_timeout=1.
  - Both counters are 16-bit, saturate at 16'hFFFF and reset to 0 by rst_n.
- Undefined: stat_done and stat_tmo are tied to 0 and no counter logic is built.

Test Plan:
1. Reset, then req N=64 (rsp_ready=1) -> req_ready falls; dp_ld high for exactly 1 cycle; datapath sequence (64,1),(32,2),(17,3),(10,6),(8,8); rsp_valid with rsp_data=8, rsp_iters=4, rsp_timeout=0; rsp_valid asserts 7 cycles after accept.
2. N=4, MIN_ITERS=2 -> dp_flag=1 at iter_cnt 0 and 1 is ignored; rsp_data=2, rsp_iters=2.
3. N=0 -> dp_ld never asserts; rsp_valid the cycle after accept; rsp_data=0, rsp_iters=0.
4. MAX_ITERS=3, N=64 -> rsp_timeout=1, rsp_data=6, rsp_iters=3. With SQRT_CTRL_STATS_EN: stat_tmo=1 and stat_done=1 after the handshake.
5. N=64 with rsp_ready held 0 for 5 cycles -> rsp_* stable and req_ready=0 throughout; handshake then IDLE; back-to-back N=81 accepted the next cycle -> rsp_data=9.
6. rst_n pulsed low during ITER of N=200 -> rsp_valid=0 and req_ready=1 immediately; no response; next N=16 -> rsp_data=4.
